// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: packs a UART byte stream MSB-first into 32-bit words and
// writes them at ascending addresses, holding the pipeline while a load is in progress.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for i_start
// RECV  | collecting bytes of the current word
// WRITE | single cycle with o_we=1 for the completed word
// DONE  | load finished (HALT_WORD written or memory full)
module instr_mem_loader #(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned MAX_ADDR  = 252
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_we,
    output logic [31:0] o_inst_data,
    output logic [31:0] o_instruction_addr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overflow
);

    localparam logic [31:0] STEP     = 32'(ADDR_STEP);
    localparam logic [31:0] LAST_ADR = 32'(MAX_ADDR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] word_q,  word_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [31:0] addr_q,  addr_d;
    logic        ovf_q,   ovf_d;
    logic        byte_ok;

    // A byte landing in the WRITE cycle already belongs to the next word.
    assign byte_ok = i_rx_valid && ((state_q == RECV) || (state_q == WRITE));

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            word_q  <= 32'd0;
            cnt_q   <= 2'd0;
            addr_q  <= 32'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q;

        if (byte_ok) begin
            word_d = {word_q[23:0], i_rx_data};
            cnt_d  = cnt_q + 2'd1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d = RECV;
                    word_d  = 32'd0;
                    cnt_d   = 2'd0;
                    addr_d  = 32'd0;
                    ovf_d   = 1'b0;
                end
            end
            RECV: begin
                if (byte_ok && (cnt_q == 2'd3)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if ((word_q == HALT_WORD) || (addr_q == LAST_ADR)) begin
                    state_d = DONE;
                    ovf_d   = (addr_q == LAST_ADR) && (word_q != HALT_WORD);
                end else begin
                    state_d = RECV;
                    addr_d  = addr_q + STEP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word register and address are stable through WRITE since they only update on its exit.
    assign o_we               = (state_q == WRITE);
    assign o_inst_data        = word_q;
    assign o_instruction_addr = addr_q;
    assign o_busy             = (state_q == RECV) || (state_q == WRITE);
    assign o_done             = (state_q == DONE);
    assign o_overflow         = ovf_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: inputs change on the falling edge, outputs are
// checked on the falling edge, expected values are hand-computed constants.
module tb_instr_mem_loader;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_we;
    logic [31:0] o_inst_data;
    logic [31:0] o_instruction_addr;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    logic we_prev = 1'b0;
    logic we_twice = 1'b0;

    instr_mem_loader dut (
        .clk                (clk),
        .i_reset            (i_reset),
        .i_start            (i_start),
        .i_rx_data          (i_rx_data),
        .i_rx_valid         (i_rx_valid),
        .o_we               (o_we),
        .o_inst_data        (o_inst_data),
        .o_instruction_addr (o_instruction_addr),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_overflow         (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_we) we_count++;
        if (o_we && we_prev) we_twice = 1'b1;
        we_prev = o_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    // Four back-to-back bytes; returns in the WRITE cycle of this word.
    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_write(input string tag, input logic [31:0] data, input logic [31:0] addr);
        chk({tag, "_we"}, {31'd0, o_we}, 32'd1);
        chk({tag, "_data"}, o_inst_data, data);
        chk({tag, "_addr"}, o_instruction_addr, addr);
        chk({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
    endtask

    initial begin
        int wc;
        i_reset    = 1'b0;
        i_start    = 1'b0;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        idle(2);
        chk("rst_we", {31'd0, o_we}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
        chk("rst_addr", o_instruction_addr, 32'd0);
        chk("rst_data", o_inst_data, 32'd0);
        i_reset = 1'b1;
        idle(1);

        // Bytes in IDLE are ignored
        send_byte(8'hAA);
        idle(2);
        chk("idle_we_cnt", we_count, 32'd0);
        chk("idle_busy", {31'd0, o_busy}, 32'd0);

        // Test 1: single word, spaced bytes
        pulse_start();
        chk("t1_busy0", {31'd0, o_busy}, 32'd1);
        send_byte(8'h20); idle(1);
        send_byte(8'h08); idle(2);
        chk("t1_busy2", {31'd0, o_busy}, 32'd1);
        chk("t1_nowe", {31'd0, o_we}, 32'd0);
        send_byte(8'h00); idle(1);
        send_byte(8'h05);
        chk_write("t1", 32'h2008_0005, 32'd0);
        idle(1);
        chk("t1_we_off", {31'd0, o_we}, 32'd0);
        chk("t1_addr_adv", o_instruction_addr, 32'd4);
        chk("t1_busy_after", {31'd0, o_busy}, 32'd1);

        // Test 2: second word then HALT
        send_word(32'h1122_3344);
        chk_write("t2_w1", 32'h1122_3344, 32'd4);
        idle(1);
        send_word(32'hFFFF_FFFF);
        chk_write("t2_halt", 32'hFFFF_FFFF, 32'd8);
        idle(1);
        chk("t2_done", {31'd0, o_done}, 32'd1);
        chk("t2_ovf", {31'd0, o_overflow}, 32'd0);
        chk("t2_busy", {31'd0, o_busy}, 32'd0);
        chk("t2_we_cnt", we_count, 32'd3);
        send_word(32'h0102_0304);
        idle(2);
        chk("t2_done_ignore", we_count, 32'd3);

        // Test 6a + 3: restart from DONE, fully back-to-back bytes
        pulse_start();
        chk("t6_done_clr", {31'd0, o_done}, 32'd0);
        chk("t6_busy", {31'd0, o_busy}, 32'd1);
        chk("t6_addr0", o_instruction_addr, 32'd0);
        send_word(32'hA1A2_A3A4);
        chk_write("t3_w0", 32'hA1A2_A3A4, 32'd0);
        send_word(32'hB1B2_B3B4);
        chk_write("t3_w1", 32'hB1B2_B3B4, 32'd4);

        // Test 6b: i_start mid-RECV is ignored
        idle(1);
        send_byte(8'hC1);
        send_byte(8'hC2);
        pulse_start();
        send_byte(8'hC3);
        send_byte(8'hC4);
        chk_write("t6_midstart", 32'hC1C2_C3C4, 32'd8);
        idle(1);
        send_word(32'hFFFF_FFFF);
        chk_write("t6_halt", 32'hFFFF_FFFF, 32'd12);
        idle(1);
        chk("t6_done", {31'd0, o_done}, 32'd1);

        // Test 4: 64 non-halt words fill memory
        pulse_start();
        for (int i = 0; i < 64; i++) begin
            send_word({8'(i), 8'h5A, 8'h00, 8'h01});
            chk_write("t4_word", {8'(i), 8'h5A, 8'h00, 8'h01}, 32'(i * 4));
        end
        idle(1);
        chk("t4_done", {31'd0, o_done}, 32'd1);
        chk("t4_ovf", {31'd0, o_overflow}, 32'd1);
        chk("t4_busy", {31'd0, o_busy}, 32'd0);
        chk("t4_addr_hold", o_instruction_addr, 32'd252);
        wc = we_count;
        send_word(32'h1234_5678);
        idle(3);
        chk("t4_no_more_we", we_count, wc);

        // HALT landing exactly on MAX_ADDR leaves overflow clear
        pulse_start();
        chk("t6_ovf_clr", {31'd0, o_overflow}, 32'd0);
        for (int i = 0; i < 63; i++) begin
            send_word(32'h0000_0013);
            idle(1);
        end
        send_word(32'hFFFF_FFFF);
        chk_write("halt_max", 32'hFFFF_FFFF, 32'd252);
        idle(1);
        chk("halt_max_done", {31'd0, o_done}, 32'd1);
        chk("halt_max_ovf", {31'd0, o_overflow}, 32'd0);

        // Test 5: async reset mid-word
        pulse_start();
        send_byte(8'hDE);
        send_byte(8'hAD);
        #2 i_reset = 1'b0;
        #1;
        chk("t5_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("t5_rst_we", {31'd0, o_we}, 32'd0);
        chk("t5_rst_data", o_inst_data, 32'd0);
        chk("t5_rst_addr", o_instruction_addr, 32'd0);
        chk("t5_rst_done", {31'd0, o_done}, 32'd0);
        @(negedge clk);
        i_reset = 1'b1;
        idle(1);
        pulse_start();
        send_word(32'h0C0D_0E0F);
        chk_write("t5_fresh", 32'h0C0D_0E0F, 32'd0);
        idle(1);

        chk("we_single_cycle", {31'd0, we_twice}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
